// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

    // Fetch control states.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // addi x0, x0, 0 -- the architectural NOP used for bubbles.
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Default byte-address width, matching the 64-word instruction memory.
    localparam int unsigned PC_WIDTH_DEF = 8;

    // Sequential fetch step in bytes.
    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load, bubble and hold controls.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                bubble,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [31:0]         instr,
    output logic                valid,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic [31:0]         id_instr
);

    // Bubble beats load; a bubble keeps id_pc so decode still sees the last PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            id_pc    <= '0;
            id_instr <= NOP;
        end else if (bubble) begin
            valid    <= 1'b0;
            id_instr <= NOP;
        end else if (load) begin
            valid    <= 1'b1;
            id_pc    <= pc;
            id_instr <= instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC, next-PC selection, fetch FSM and fetch counter.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned          PC_WIDTH  = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
    parameter int unsigned          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic [31:0]          imem_instr,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [PC_WIDTH-1:0]  redirect_target,
    input  logic                 halt_req,
    output logic                 id_valid,
    output logic [PC_WIDTH-1:0]  id_pc,
    output logic [31:0]          id_instr,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    fetch_state_e        state;
    logic [PC_WIDTH-1:0] pc;
    logic                active;
    logic                do_redirect;
    logic                do_advance;
    logic                do_bubble;
    logic [PC_WIDTH-1:0] target_aligned;

    // Redirect targets are forced to word alignment; the low bits are dropped.
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^redirect_target[1:0];
    assign target_aligned     = {redirect_target[PC_WIDTH-1:2], 2'b00};

    // Priority: halt > redirect > stall > advance; nothing moves once halted.
    assign active      = (state != HALT);
    assign do_redirect = active && !halt_req && redirect_valid;
    assign do_advance  = active && !halt_req && !redirect_valid && !stall;
    assign do_bubble   = active && (halt_req || redirect_valid);

    assign imem_addr = pc;

    // Fetch FSM; halted is kept as its own flop so the output is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= BOOT;
            halted <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    if (halt_req) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state  <= BOOT;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    // Program counter: redirect target, sequential step, or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (do_redirect) begin
            pc <= target_aligned;
        end else if (do_advance) begin
            pc <= pc + PC_WIDTH'(PC_INC);
        end
    end

    // Count instructions delivered to decode; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (do_advance) begin
            fetch_count <= fetch_count + CNT_WIDTH'(1);
        end
    end

    if_id_reg #(
        .PC_WIDTH (PC_WIDTH)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (do_advance),
        .bubble   (do_bubble),
        .pc       (pc),
        .instr    (imem_instr),
        .valid    (id_valid),
        .id_pc    (id_pc),
        .id_instr (id_instr)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 64-word behavioural instruction memory.
module tb_fetch_stage;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic        halt_req;
    logic        id_valid;
    logic [7:0]  id_pc;
    logic [31:0] id_instr;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] mem [64];

    int tests;
    int fails;

    fetch_stage #(
        .PC_WIDTH  (8),
        .RESET_PC  (8'h00),
        .CNT_WIDTH (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_instr        (id_instr),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    assign imem_instr = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_if(input string tag, input logic v, input logic [7:0] pc,
                             input logic [31:0] ins, input logic [7:0] addr,
                             input logic [15:0] cnt, input logic h);
        check({tag, ".id_valid"},    32'(v),    32'(id_valid));
        check({tag, ".id_pc"},       32'(pc),   32'(id_pc));
        check({tag, ".id_instr"},    ins,       id_instr);
        check({tag, ".imem_addr"},   32'(addr), 32'(imem_addr));
        check({tag, ".fetch_count"}, 32'(cnt),  32'(fetch_count));
        check({tag, ".halted"},      32'(h),    32'(halted));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0100_0000 + 32'(i);
        mem[0]  = 32'h0000_7033;
        mem[1]  = 32'h0030_0093;
        mem[2]  = 32'h0020_0113;
        mem[3]  = 32'h0030_8193;
        mem[18] = 32'h02B0_2823;

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = 8'h00; halt_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        // Cycle 0: BOOT, reset values visible.
        expect_if("reset", 1'b0, 8'h00, NOP_W, 8'h00, 16'd0, 1'b0);
        step();
        expect_if("fetch0", 1'b1, 8'h00, 32'h0000_7033, 8'h04, 16'd1, 1'b0);
        step();
        expect_if("fetch1", 1'b1, 8'h04, 32'h0030_0093, 8'h08, 16'd2, 1'b0);
        step();
        expect_if("fetch2", 1'b1, 8'h08, 32'h0020_0113, 8'h0C, 16'd3, 1'b0);

        // Stall three cycles at PC=0x0C.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_if("stall", 1'b1, 8'h08, 32'h0020_0113, 8'h0C, 16'd3, 1'b0);
        end
        stall = 1'b0;
        step();
        expect_if("stall_rel", 1'b1, 8'h0C, 32'h0030_8193, 8'h10, 16'd4, 1'b0);
        step();
        expect_if("fetch4", 1'b1, 8'h10, 32'h0100_0004, 8'h14, 16'd5, 1'b0);

        // Misaligned redirect at PC=0x14.
        redirect_valid = 1'b1; redirect_target = 8'h4B;
        step();
        redirect_valid = 1'b0;
        expect_if("redir", 1'b0, 8'h10, NOP_W, 8'h48, 16'd5, 1'b0);
        step();
        expect_if("redir_tgt", 1'b1, 8'h48, 32'h02B0_2823, 8'h4C, 16'd6, 1'b0);

        // Redirect and stall together: redirect wins.
        redirect_valid = 1'b1; redirect_target = 8'h20; stall = 1'b1;
        step();
        redirect_valid = 1'b0; stall = 1'b0;
        expect_if("redir_stall", 1'b0, 8'h48, NOP_W, 8'h20, 16'd6, 1'b0);
        step();
        expect_if("redir_stall_tgt", 1'b1, 8'h20, 32'h0100_0008, 8'h24, 16'd7, 1'b0);

        // Wrap-around from 0xFC to 0x00.
        redirect_valid = 1'b1; redirect_target = 8'hFC;
        step();
        redirect_valid = 1'b0;
        expect_if("wrap_redir", 1'b0, 8'h20, NOP_W, 8'hFC, 16'd7, 1'b0);
        step();
        expect_if("wrap_fc", 1'b1, 8'hFC, 32'h0100_003F, 8'h00, 16'd8, 1'b0);
        step();
        expect_if("wrap_00", 1'b1, 8'h00, 32'h0000_7033, 8'h04, 16'd9, 1'b0);
        step();
        step();
        step();
        expect_if("pre_halt", 1'b1, 8'h0C, 32'h0030_8193, 8'h10, 16'd12, 1'b0);

        // Halt at PC=0x10; later redirects and stalls are ignored.
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        expect_if("halt", 1'b0, 8'h0C, NOP_W, 8'h10, 16'd12, 1'b1);
        redirect_valid = 1'b1; redirect_target = 8'h40;
        step();
        expect_if("halt_redir", 1'b0, 8'h0C, NOP_W, 8'h10, 16'd12, 1'b1);
        redirect_valid = 1'b0;
        step();
        expect_if("halt_hold", 1'b0, 8'h0C, NOP_W, 8'h10, 16'd12, 1'b1);

        // Reset out of HALT.
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_if("rst_halt", 1'b0, 8'h00, NOP_W, 8'h00, 16'd0, 1'b0);
        step();
        expect_if("rst_fetch0", 1'b1, 8'h00, 32'h0000_7033, 8'h04, 16'd1, 1'b0);

        // Halt requested in BOOT: nothing is captured.
        rst = 1'b1;
        step();
        rst = 1'b0; halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        expect_if("boot_halt", 1'b0, 8'h00, NOP_W, 8'h00, 16'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the RV32I core. It owns the program counter and drives the byte address into the instruction memory. It captures the returned word, together with its PC, into the IF/ID pipeline register that feeds decode. It handles stall, control-flow redirect and halt, and keeps a fetched-instruction counter for bring-up.

## Interface
Parameters:
- PC_WIDTH, 8, byte-address width; matches the 8-bit instruction memory address (64 words).
- RESET_PC, 8'h00, first fetch address after reset; must be word-aligned.
- CNT_WIDTH, 16, width of the fetched-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  PC_WIDTH  byte address to instruction memory; equals PC register.
- imem_instr  in  32  combinational read data for imem_addr, valid in the same cycle.
- stall  in  1  hold PC and IF/ID contents.
- redirect_valid  in  1  branch/jump taken; load new PC.
- redirect_target  in  PC_WIDTH  redirect byte address; bits [1:0] ignored.
- halt_req  in  1  stop fetching; sticky until reset.
- id_valid  out  1  IF/ID holds a real instruction.
- id_pc  out  PC_WIDTH  PC of id_instr.
- id_instr  out  32  fetched instruction; 32'h0000_0013 (NOP) when id_valid=0.
- halted  out  1  FSM is in HALT.
- fetch_count  out  CNT_WIDTH  number of instructions delivered to IF/ID.

## Operation
- FSM states:
  - BOOT: first cycle after reset.
  - RUN: normal fetching.
  - HALT: fetching stopped.
- FSM transitions:
  - rst → BOOT.
  - BOOT → RUN unconditionally. If halt_req is high in BOOT, go to HALT instead.
  - RUN → HALT when halt_req=1.
  - HALT is left only by rst.
- Reset values:
  - PC=RESET_PC.
  - id_valid=0, id_pc=0, id_instr=NOP.
  - halted=0.
  - fetch_count=0.
- Per-cycle priority: rst > halt > redirect > stall > advance.
- Advance (RUN or BOOT, no stall, no redirect):
  - IF/ID ← {1, PC, imem_instr}.
  - PC ← PC+4, modulo 2^PC_WIDTH, so 8'hFC wraps to 8'h00.
- Stall with no redirect: PC and IF/ID hold; fetch_count holds.
- Redirect, including redirect while stalled:
  - PC ← {redirect_target[PC_WIDTH-1:2], 2'b00}.
  - IF/ID ← bubble: id_valid=0, id_instr=NOP, id_pc holds.
  - The wrong-path word fetched this cycle is discarded.
- Halt request:
  - The word currently at imem_addr is not captured.
  - IF/ID ← bubble, and PC holds its value.
  - halted=1 from the next cycle.
- In HALT: stall and redirect are ignored; outputs are frozen.
- fetch_count increments by 1 on every advance that loads id_valid=1. It wraps at 2^CNT_WIDTH.

## Timing
- imem_addr is registered (PC) and valid from the clock edge. imem_instr is combinational from it.
- Fetch-to-decode latency is 1 cycle: the word at PC in cycle n appears on id_instr in cycle n+1.
- Throughput is 1 instruction per cycle when not stalled.
- Redirect costs 1 bubble:
  - Redirect asserted in cycle n.
  - Target word is fetched in cycle n+1.
  - Target word appears on id_instr in cycle n+2.
- Stall is sampled each cycle; deassertion resumes advancing at the next edge with no lost or duplicated instruction.
- rst asserted mid-operation (any state, including during stall or redirect) restores all reset values at the next edge.

## Structure
- Shared package fetch_pkg holds:
  - the FSM state enum {BOOT, RUN, HALT};
  - the NOP constant 32'h0000_0013;
  - the PC_WIDTH default;
  - the pc+4 increment constant.
- One sub-module, if_id_reg: the IF/ID pipeline register with load, bubble and hold controls. Decode-side hazard logic reuses it.
- PC register, next-PC mux, FSM and counter stay in fetch_stage.

## Test plan
- Reset release with memory preloaded with the bring-up program:
  - cycle 0: id_valid=0, imem_addr=8'h00;
  - cycle 1: id_pc=8'h00, id_instr=32'h0000_7033;
  - cycle 2: id_pc=8'h04, id_instr=32'h0030_0093;
  - fetch_count=2.
- Stall held 3 cycles when PC=8'h0C:
  - id_pc stays 8'h08 and id_instr stays 32'h0020_0113;
  - the cycle after release shows id_pc=8'h0C, id_instr=32'h0030_8193, with no duplicate or skipped instruction.
- Redirect to 8'h4B, misaligned, at PC=8'h14:
  - next cycle: id_valid=0, imem_addr=8'h48;
  - following cycle: id_pc=8'h48, id_instr=32'h02B0_2823.
- Redirect and stall asserted in the same cycle: redirect wins, PC = target, IF/ID bubble.
- Wrap-around: redirect to 8'hFC, then advance → id_pc=8'hFC, then imem_addr=8'h00.
- halt_req at PC=8'h10:
  - halted=1 next cycle, id_valid=0, PC frozen at 8'h10;
  - later redirects are ignored;
  - rst returns to BOOT with PC=8'h00 and fetch_count=0.
